video_dma: RTL and testbench
============================

Name: video_dma

Overview:
- Bus-master loader that copies a block of 32-bit words from system memory into the video unit's write ports: tile attribute RAM, tile data RAM or palette.
- It is the writer side of the tile and palette RAMs that the video unit scans out.
- The CPU programs it through a small register window; it runs entirely in the wclk domain.

Parameters:
- ADDR_WIDTH, 32, system memory byte-address width.
- TATTR_AW, 10, tattr byte-address width (1024 entries).
- TDATA_AW, 8, tdata byte-address width (256 bytes, 128 halfwords).
- LEN_WIDTH, 10, transfer length field width, in words.

Ports:
- wclk  in  1  system clock.
- rst_n  in  1  reset.
- reg_addr  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
- reg_wdata  in  32  register write data.
- reg_wenable  in  1  register write strobe.
- reg_rdata  out  32  combinational register read data.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  word-aligned read address.
- mem_ready  in  1  read data valid / request accepted.
- mem_rdata  in  32  read data.
- tattr_addr  out  TATTR_AW  tattr write address.
- tattr_wdata  out  8  tattr write data.
- tattr_wenable  out  1  tattr write strobe.
- tdata_addr  out  TDATA_AW  tdata byte address, bit0 always 0.
- tdata_wdata  out  16  tdata write data.
- tdata_wenable  out  2  tdata byte enables.
- pal_addr  out  4  palette index.
- pal_wdata  out  12  palette colour.
- pal_wenable  out  1  palette write strobe.
- busy  out  1  transfer in progress.

Behaviour:
- Reset: rst_n is synchronous, active-low, sampled on wclk.
  - All registers clear to 0 and the FSM goes to IDLE.
  - busy, mem_req and all wenables are 0; all address and data outputs are 0.
  - Reset mid-transfer aborts immediately; no further strobes are issued.
- Registers:
  - SRC[ADDR_WIDTH-1:2] holds the source address; bits 1:0 are read as 0.
  - DST[17:16] = sel (0 tattr, 1 tdata, 2 palette, 3 invalid); DST[9:0] = dst offset, in target units.
  - LEN[LEN_WIDTH-1:0] is the word count.
  - CTRL write: bit0 = start, bit1 = clear done/err.
  - CTRL read: {29'b0, err, done, busy}.
  - Writes to SRC, DST, LEN and CTRL.start are ignored while busy; CTRL.clear is always honoured.
- Starting a transfer: start copies SRC, DST and LEN into working counters and clears done and err.
  - LEN=0: no memory access; done=1 next cycle, busy never rises.
  - sel=3: err=1 and done=1 next cycle, no memory access.
- FSM states IDLE, FETCH, WRITE, FINISH.
- FETCH:
  - mem_req=1, with mem_addr = current source address held stable until mem_ready=1.
  - At the edge where mem_ready=1, the word is latched, mem_req drops and the FSM moves to WRITE.
- WRITE emits one sub-write strobe per cycle, registered outputs, each strobe high for exactly one cycle, little-endian order:
  - tattr: 4 strokes, bytes [7:0], [15:8], [23:16], [31:24], at consecutive addresses.
  - tdata: 2 strokes, halfwords [15:0] then [31:16]; tdata_wenable=2'b11; tdata_addr advances by 2.
  - palette: 2 strokes, pal_wdata = hword[11:0] (bits 15:12 discarded); pal_addr advances by 1.
- Advancing after WRITE:
  - The source address advances by 4 and the remaining count decrements.
  - If the count is non-zero, the FSM returns to FETCH; mem_req is asserted the cycle after the last strobe.
  - Otherwise it goes to FINISH: busy=0 and done=1 on the next cycle, then IDLE.
- busy=1 from the cycle after start until FINISH.
- Destination address wraps modulo target size: 2^TATTR_AW bytes, 2^TDATA_AW bytes or 16 entries. The source address wraps modulo 2^ADDR_WIDTH.
- Timing: a single word with mem_ready tied high takes 1 FETCH cycle plus k WRITE cycles (k=4 or 2), then FINISH.
- Exclusivity: never more than one wenable group is active in a cycle, and no strobe is ever issued outside WRITE.

Test Plan:
- SRC=0x100, DST=sel0/off 0x3FE, LEN=1, mem word 0xDDCCBBAA -> tattr writes (0x3FE,AA), (0x3FF,BB), (0x000,CC), (0x001,DD); done=1; busy low afterwards.
- sel1, off 0x10, LEN=2, words 0x22221111 and 0x44443333 -> tdata writes 0x10:1111, 0x12:2222, 0x14:3333, 0x16:4444; mem_addr 0x100 then 0x104.
- sel2, off 15, LEN=1, word 0xF0AB_E123 -> pal[15]=0x123, pal[0]=0x0AB.
- mem_ready held low 5 cycles -> mem_req and mem_addr stable throughout, zero strobes; transfer completes normally once ready.
- LEN=0 start -> done=1 after 1 cycle, mem_req never asserted. sel=3 -> err=1 and done=1. Start or SRC write while busy -> ignored.
- rst_n low during the 2nd tattr strobe -> all outputs 0 next edge, busy=0, done=0; a subsequent fresh start works.

Source files
------------

// File: rtl/video_dma.sv
// Register-programmed loader that copies 32-bit words from system memory into
// the tile attribute RAM, tile data RAM or palette write ports.
module video_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int TATTR_AW   = 10,
  parameter int TDATA_AW   = 8,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic [1:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  input  logic                  reg_wenable,
  output logic [31:0]           reg_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [TATTR_AW-1:0]   tattr_addr,
  output logic [7:0]            tattr_wdata,
  output logic                  tattr_wenable,
  output logic [TDATA_AW-1:0]   tdata_addr,
  output logic [15:0]           tdata_wdata,
  output logic [1:0]            tdata_wenable,
  output logic [3:0]            pal_addr,
  output logic [11:0]           pal_wdata,
  output logic                  pal_wenable,
  output logic                  busy
);

  // Destination counter is wide enough for the largest target; each target
  // takes its own low bits, which gives the modulo wrap for free.
  localparam int CW0 = (TATTR_AW > TDATA_AW) ? TATTR_AW : TDATA_AW;
  localparam int CW  = (CW0 > 10) ? CW0 : 10;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-3:0]   src_reg;
  logic [1:0]              sel_reg;
  logic [9:0]              off_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic                    done_reg;
  logic                    err_reg;

  logic [ADDR_WIDTH-3:0]   src_cnt;
  logic [CW-1:0]           dst_cnt;
  logic [LEN_WIDTH-1:0]    len_cnt;
  logic [1:0]              sel_cur;
  logic [31:0]             word_reg;
  logic [1:0]              idx_reg;

  logic                    start_fire;
  logic                    cfg_we;
  logic                    emit;
  logic [31:0]             wr_word;
  logic [1:0]              wr_idx;
  logic [7:0]              wr_byte;
  logic [15:0]             wr_half;
  logic [1:0]              last_idx;
  logic [1:0]              step;
  logic [ADDR_WIDTH-3:0]   src_nxt;

  assign cfg_we     = reg_wenable && !busy;
  assign start_fire = cfg_we && (reg_addr == 2'd3) && reg_wdata[0];
  assign src_nxt    = src_cnt + 1'b1;

  // The first stroke is issued straight from mem_rdata on the accepting edge so
  // that it is visible in the first WRITE cycle.
  always_comb begin
    wr_word  = (state_reg == FETCH) ? mem_rdata : word_reg;
    wr_idx   = (state_reg == FETCH) ? 2'd0 : idx_reg + 2'd1;
    last_idx = (sel_cur == 2'd0) ? 2'd3 : 2'd1;
    step     = (sel_cur == 2'd1) ? 2'd2 : 2'd1;
    emit     = ((state_reg == FETCH) && mem_ready) ||
               ((state_reg == WRITE) && (idx_reg != last_idx));
    case (wr_idx)
      2'd0:    wr_byte = wr_word[7:0];
      2'd1:    wr_byte = wr_word[15:8];
      2'd2:    wr_byte = wr_word[23:16];
      default: wr_byte = wr_word[31:24];
    endcase
    wr_half = wr_idx[0] ? wr_word[31:16] : wr_word[15:0];
  end

  always_comb begin
    case (reg_addr)
      2'd0:    reg_rdata = 32'({src_reg, 2'b00});
      2'd1:    reg_rdata = {14'b0, sel_reg, 6'b0, off_reg};
      2'd2:    reg_rdata = 32'(len_reg);
      default: reg_rdata = {29'b0, err_reg, done_reg, busy};
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      sel_reg       <= '0;
      off_reg       <= '0;
      len_reg       <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      src_cnt       <= '0;
      dst_cnt       <= '0;
      len_cnt       <= '0;
      sel_cur       <= '0;
      word_reg      <= '0;
      idx_reg       <= '0;
      busy          <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      tattr_addr    <= '0;
      tattr_wdata   <= '0;
      tattr_wenable <= 1'b0;
      tdata_addr    <= '0;
      tdata_wdata   <= '0;
      tdata_wenable <= '0;
      pal_addr      <= '0;
      pal_wdata     <= '0;
      pal_wenable   <= 1'b0;
    end else begin
      tattr_wenable <= 1'b0;
      tdata_wenable <= 2'b00;
      pal_wenable   <= 1'b0;

      if (cfg_we) begin
        case (reg_addr)
          2'd0: src_reg <= (ADDR_WIDTH-2)'(reg_wdata >> 2);
          2'd1: begin
            sel_reg <= reg_wdata[17:16];
            off_reg <= reg_wdata[9:0];
          end
          2'd2: len_reg <= LEN_WIDTH'(reg_wdata);
          default: ;
        endcase
      end
      if (reg_wenable && (reg_addr == 2'd3) && reg_wdata[1]) begin
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
      end

      if (start_fire) begin
        done_reg <= 1'b0;
        err_reg  <= 1'b0;
        src_cnt  <= src_reg;
        dst_cnt  <= CW'(off_reg);
        len_cnt  <= len_reg;
        sel_cur  <= sel_reg;
        idx_reg  <= 2'd0;
        if (sel_reg == 2'd3) begin
          err_reg   <= 1'b1;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end else if (len_reg == '0) begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end else begin
          state_reg <= FETCH;
          busy      <= 1'b1;
          mem_req   <= 1'b1;
          mem_addr  <= {src_reg, 2'b00};
        end
      end else begin
        case (state_reg)
          FETCH: if (mem_ready) begin
            word_reg  <= mem_rdata;
            mem_req   <= 1'b0;
            state_reg <= WRITE;
          end
          WRITE: if (idx_reg == last_idx) begin
            src_cnt <= src_nxt;
            len_cnt <= len_cnt - 1'b1;
            if (len_cnt != LEN_WIDTH'(1)) begin
              state_reg <= FETCH;
              mem_req   <= 1'b1;
              mem_addr  <= {src_nxt, 2'b00};
            end else begin
              state_reg <= FINISH;
              busy      <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
          FINISH: state_reg <= IDLE;
          default: ;
        endcase

        if (emit) begin
          idx_reg <= wr_idx;
          dst_cnt <= dst_cnt + CW'(step);
          case (sel_cur)
            2'd0: begin
              tattr_addr    <= dst_cnt[TATTR_AW-1:0];
              tattr_wdata   <= wr_byte;
              tattr_wenable <= 1'b1;
            end
            2'd1: begin
              tdata_addr    <= {dst_cnt[TDATA_AW-1:1], 1'b0};
              tdata_wdata   <= wr_half;
              tdata_wenable <= 2'b11;
            end
            default: begin
              pal_addr    <= dst_cnt[3:0];
              pal_wdata   <= wr_half[11:0];
              pal_wenable <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_video_dma.sv
// Directed bench for video_dma: programs transfers through the register window
// and checks the captured RAM/palette write streams against hand-computed values.
module tb_video_dma;

  logic        wclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic        reg_wenable = 1'b0;
  logic [31:0] reg_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [9:0]  tattr_addr;
  logic [7:0]  tattr_wdata;
  logic        tattr_wenable;
  logic [7:0]  tdata_addr;
  logic [15:0] tdata_wdata;
  logic [1:0]  tdata_wenable;
  logic [3:0]  pal_addr;
  logic [11:0] pal_wdata;
  logic        pal_wenable;
  logic        busy;

  logic [31:0] mem_word [16];
  logic        ready_en = 1'b0;

  assign mem_rdata = mem_word[mem_addr[5:2]];
  assign mem_ready = ready_en;

  always #5 wclk = ~wclk;

  video_dma dut (
    .wclk(wclk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wenable(reg_wenable),
    .reg_rdata(reg_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .tattr_addr(tattr_addr), .tattr_wdata(tattr_wdata), .tattr_wenable(tattr_wenable),
    .tdata_addr(tdata_addr), .tdata_wdata(tdata_wdata), .tdata_wenable(tdata_wenable),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_wenable(pal_wenable),
    .busy(busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] wq[$];
  logic [31:0] aq[$];
  int          strobes = 0;
  int          excl_err = 0;
  bit          req_seen = 1'b0;

  // Capture every strobe and every accepted fetch address.
  always @(negedge wclk) begin
    int n;
    n = int'(tattr_wenable) + int'(|tdata_wenable) + int'(pal_wenable);
    if (tattr_wenable) wq.push_back({14'b0, tattr_addr, tattr_wdata});
    if (|tdata_wenable) wq.push_back({6'b0, tdata_wenable, tdata_addr, tdata_wdata});
    if (pal_wenable) wq.push_back({16'b0, pal_addr, pal_wdata});
    strobes = strobes + n;
    if (n > 1) excl_err = excl_err + 1;
    if (mem_req) req_seen = 1'b1;
    if (mem_req && mem_ready) aq.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors = vectors + 1;
    assert (observed === expected) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge wclk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_addr    = a;
    reg_wdata   = d;
    reg_wenable = 1'b1;
    step();
    reg_wenable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] wget(input int i);
    return (wq.size() > i) ? wq[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] aget(input int i);
    return (aq.size() > i) ? aq[i] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 16; i++) mem_word[i] = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wen", {29'b0, tattr_wenable, tdata_wenable}, 32'd0);
    rd(2'd3, r);
    chk("rst_ctrl", r, 32'd0);
    rst_n = 1'b1;
    step();

    // tattr transfer wrapping past the top of the RAM
    reg_write(2'd0, 32'h103);
    rd(2'd0, r);
    chk("src_readback", r, 32'h100);
    reg_write(2'd1, 32'h0000_03FE);
    reg_write(2'd2, 32'd1);
    mem_word[0] = 32'hDDCC_BBAA;
    ready_en = 1'b1;
    wq.delete();
    aq.delete();
    reg_write(2'd3, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_req", {31'b0, mem_req}, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    wait_idle("t1");
    rd(2'd3, r);
    chk("t1_ctrl", r, 32'd2);
    chk("t1_count", wq.size(), 32'd4);
    chk("t1_w0", wget(0), 32'h0003_FEAA);
    chk("t1_w1", wget(1), 32'h0003_FFBB);
    chk("t1_w2", wget(2), 32'h0000_00CC);
    chk("t1_w3", wget(3), 32'h0000_01DD);
    $display("xfer tattr: %0d writes", wq.size());

    // tdata, two words
    reg_write(2'd1, 32'h0001_0010);
    reg_write(2'd2, 32'd2);
    mem_word[0] = 32'h2222_1111;
    mem_word[1] = 32'h4444_3333;
    wq.delete();
    aq.delete();
    reg_write(2'd3, 32'd1);
    wait_idle("t2");
    chk("t2_count", wq.size(), 32'd4);
    chk("t2_w0", wget(0), 32'h0310_1111);
    chk("t2_w1", wget(1), 32'h0312_2222);
    chk("t2_w2", wget(2), 32'h0314_3333);
    chk("t2_w3", wget(3), 32'h0316_4444);
    chk("t2_a0", aget(0), 32'h100);
    chk("t2_a1", aget(1), 32'h104);
    $display("xfer tdata: %0d writes", wq.size());

    // palette, wrapping at index 15
    reg_write(2'd1, 32'h0002_000F);
    reg_write(2'd2, 32'd1);
    mem_word[0] = 32'hF0AB_E123;
    wq.delete();
    reg_write(2'd3, 32'd1);
    wait_idle("t3");
    chk("t3_count", wq.size(), 32'd2);
    chk("t3_w0", wget(0), 32'h0000_F123);
    chk("t3_w1", wget(1), 32'h0000_00AB);
    $display("xfer palette: %0d writes", wq.size());

    // LEN=0: done without touching memory
    reg_write(2'd3, 32'd2);
    rd(2'd3, r);
    chk("clr_ctrl", r, 32'd0);
    reg_write(2'd2, 32'd0);
    req_seen = 1'b0;
    reg_write(2'd3, 32'd1);
    rd(2'd3, r);
    chk("len0_ctrl", r, 32'd2);
    step();
    step();
    chk("len0_noreq", {31'b0, req_seen}, 32'd0);
    $display("xfer len0: done");

    // sel=3: error
    reg_write(2'd1, 32'h0003_0000);
    reg_write(2'd2, 32'd1);
    reg_write(2'd3, 32'd1);
    rd(2'd3, r);
    chk("sel3_ctrl", r, 32'd6);
    step();
    chk("sel3_noreq", {31'b0, req_seen}, 32'd0);
    $display("xfer sel3: err");

    // Stalled memory, plus writes while busy
    ready_en = 1'b0;
    reg_write(2'd0, 32'h104);
    reg_write(2'd1, 32'h0000_0000);
    reg_write(2'd2, 32'd1);
    wq.delete();
    strobes = 0;
    reg_write(2'd3, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'b0, mem_req}, 32'd1);
      chk("stall_addr", mem_addr, 32'h104);
      step();
    end
    chk("stall_nostrobe", strobes, 32'd0);
    reg_write(2'd0, 32'h200);
    rd(2'd0, r);
    chk("busy_src_ignored", r, 32'h104);
    reg_write(2'd3, 32'd1);
    chk("busy_start_ignored", mem_addr, 32'h104);
    ready_en = 1'b1;
    wait_idle("stall");
    chk("stall_count", strobes, 32'd4);
    chk("stall_w0", wget(0), 32'h0000_0033);
    chk("stall_w3", wget(3), 32'h0000_0344);
    $display("xfer stall: %0d writes", wq.size());

    // Reset during the second tattr strobe
    reg_write(2'd0, 32'h100);
    mem_word[0] = 32'hDDCC_BBAA;
    strobes = 0;
    reg_write(2'd3, 32'd1);
    for (int n = 0; n < 20 && strobes < 2; n++) step();
    chk("mid_two_strobes", strobes, 32'd2);
    rst_n = 1'b0;
    step();
    chk("mid_wen", {29'b0, tattr_wenable, tdata_wenable}, 32'd0);
    chk("mid_tattr", {14'b0, tattr_addr, tattr_wdata}, 32'd0);
    chk("mid_mem", {mem_addr[30:0], mem_req}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    rd(2'd3, r);
    chk("mid_ctrl", r, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("mid_no_more", strobes, 32'd2);

    // Fresh start after reset
    reg_write(2'd0, 32'h100);
    reg_write(2'd1, 32'h0000_0005);
    reg_write(2'd2, 32'd1);
    wq.delete();
    reg_write(2'd3, 32'd1);
    wait_idle("post");
    chk("post_count", wq.size(), 32'd4);
    chk("post_w0", wget(0), 32'h0000_05AA);
    chk("post_w3", wget(3), 32'h0000_08DD);
    rd(2'd3, r);
    chk("post_ctrl", r, 32'd2);
    $display("xfer post-reset: %0d writes", wq.size());

    chk("exclusive", excl_err, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
